// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Segment patterns are active low, bit 6 = segment a, bit 0 = segment g.
package seg_pkg;

    localparam int DEF_N_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_e;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD to active-low segment decode.
// Nibbles A-F and an asserted blank input both produce an all-off pattern.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// Loads land in a pending buffer that is promoted to the active buffer only at frame wrap.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = DEF_N_DIGITS,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done,
    output phase_e                dbg_phase,
    output logic [$clog2((N_DIGITS > 1) ? N_DIGITS : 2)-1:0] dbg_idx
);

    localparam int                IDX_W     = $clog2((N_DIGITS > 1) ? N_DIGITS : 2);
    localparam int                CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_C   = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam phase_e            PHASE_RST = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    phase_e                phase_q, phase_d;
    logic [4*N_DIGITS-1:0] pend_value_q, pend_value_d, act_value_q, act_value_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                  pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_done_q, frame_done_d;
    logic                  wrap_pend_q, wrap_pend_d;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  upper_zero;
    logic                  lz_hide;
    logic [6:0]            dec_seg;

    // Scan position, phase and buffer promotion.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wrap         = 1'b0;
        phase_d      = phase_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_lz_d    = pend_lz_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_lz_d     = act_lz_q;

        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (phase_q)
            BLANK:   if (cnt_d >= BLANK_C) phase_d = DRIVE;
            DRIVE:   if (cnt_d < BLANK_C) phase_d = BLANK;
            default: phase_d = PHASE_RST;
        endcase

        // Promotion reads the pending contents from before any same-cycle load.
        if (wrap) begin
            act_value_d = pend_value_q;
            act_dp_d    = pend_dp_q;
            act_lz_d    = pend_lz_q;
        end
        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp_in;
            pend_lz_d    = lz_blank;
        end
    end

    // Digit select and leading-zero detection for the current index.
    always_comb begin
        nib        = 4'd0;
        dp_bit     = 1'b0;
        upper_zero = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib    = act_value_q[4*i +: 4];
                dp_bit = act_dp_q[i];
            end
            if (IDX_W'(i) >= idx_q && act_value_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        lz_hide = act_lz_q && upper_zero && (idx_q != '0);
    end

    seg_digit_decode u_decode (
        .nibble (nib),
        .blank  (lz_hide),
        .seg    (dec_seg)
    );

    // frame_done waits for the first enabled cycle of the new frame.
    always_comb begin
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        an_d         = '1;
        frame_done_d = enable && wrap_pend_q;
        wrap_pend_d  = enable ? wrap : wrap_pend_q;
        if (enable && phase_q == DRIVE) begin
            seg_d = dec_seg;
            dp_d  = ~dp_bit;
            for (int i = 0; i < N_DIGITS; i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            phase_q      <= PHASE_RST;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_lz_q    <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_lz_q     <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
            wrap_pend_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            wrap_pend_q  <= wrap_pend_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign dbg_phase  = phase_q;
    assign dbg_idx    = idx_q;

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan controller for the board's 4-digit common-anode 7-segment display. It holds a 4-digit BCD value and steps through the digits one at a time, driving a single shared active-low segment bus and one active-low anode per digit. Loads are double-buffered so the display only changes at frame boundaries, and a blanking gap at the start of each digit slot suppresses ghosting. It sits between the lab datapath (counters, ALU results) and the top-level pin outputs.

## Interface
- N_DIGITS, 4: number of digits scanned; digit 0 is rightmost.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, 2000: cycles at the start of each slot with all anodes off.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; low blanks the display and holds the scan position.
- load  in  1  single-cycle strobe; capture value/dp_in/lz_blank into the pending buffer.
- value  in  4*N_DIGITS  BCD digits; nibble i is digit i.
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit.
- lz_blank  in  1  leading-zero suppression request, captured with load.
- seg  out  7  segments a..g, active low (bit 6 = a).
- dp  out  1  decimal point, active low.
- an  out  N_DIGITS  anodes, active low, at most one low at any time.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

## Operation
- Registers: pending buffer (value, dp, lz), active buffer, slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..N_DIGITS-1), phase state.
- Phase state machine per slot: BLANK while cnt < BLANK_CYCLES, DRIVE otherwise. BLANK→DRIVE at cnt = BLANK_CYCLES. DRIVE→BLANK at cnt = REFRESH_DIV-1, when cnt→0 and idx advances.
- idx wraps N_DIGITS-1 → 0. On that wrap cycle, active ← pending, and frame_done pulses.
- A load on the wrap cycle is written to pending but not transferred; it appears on the next frame. Multiple loads within one frame: the last load wins.
- Decoding in DRIVE: active-low patterns 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
- Non-BCD nibbles (A–F) force seg = 1111111. The output must never hold a stale pattern.
- Leading-zero blanking: if active lz is set, digit i is blanked (seg = 1111111, dp still honoured) when nibbles N_DIGITS-1..i are all zero and i ≠ 0. Digit 0 always displays.
- In BLANK: an = all 1, seg = 1111111, dp = 1.
- enable low: an = all 1, seg = 1111111, dp = 1. cnt and idx hold, and frame_done stays 0. Loads into pending are still accepted. Scanning resumes from the held position when enable returns high.
- Reset values: an = all 1, seg = 1111111, dp = 1, frame_done = 0, cnt = 0, idx = 0. Both buffers are cleared to value 0, dp 0, lz 0. Reset mid-frame discards pending data immediately.

## Timing
- seg, dp, an, and frame_done are registered: they reflect the cnt/idx/phase/buffer state of the previous cycle.
- After reset deasserts on cycle 0, an[0] first goes low at cycle BLANK_CYCLES+1. It stays low for REFRESH_DIV-BLANK_CYCLES cycles.
- Frame period = N_DIGITS*REFRESH_DIV cycles.
- Load-to-visible latency: the data is shown from the first DRIVE output of the frame following the next wrap.
- frame_done is high for exactly one cycle, coincident with the first registered output of the new frame.

## Structure
- Shared package seg_pkg holds:
  - SEG_BLANK = 7'b1111111,
  - the digit pattern constants 0–9,
  - the phase enum {BLANK, DRIVE},
  - default N_DIGITS.
- One sub-module, seg_digit_decode: combinational BCD→seg with a blank input and invalid-nibble blanking.
- The top level is instantiated once per display.

## Test plan
Run with REFRESH_DIV=8 and BLANK_CYCLES=2.
- Reset then enable=1, no load → an cycles 1110,1101,1011,0111, each low for 6 cycles, with 2 blank cycles (an=1111) between slots. seg=0000001 throughout DRIVE, and frame_done pulses every 32 cycles.
- load value=16'h1234, dp_in=4'b0100 mid-frame → the current frame still shows 0s. The next frame shows digit0 seg=1001100 (4) and digit2 seg=0010010 (2) with dp=0 only on digit2.
- load 16'h0007 with lz_blank=1 → digits 3..1 seg=1111111 and digit0 seg=0001111. A second load of 16'h0000 with lz=1 → only digit0 is lit, showing 0.
- load 16'h00A9 → digit1 seg=1111111 (invalid nibble) and digit0 seg=0001100.
- load asserted exactly on the wrap cycle with 16'h5555 → the frame after shows the old value, and the frame after that shows 5s (seg=0100100).
- enable dropped mid-slot for 10 cycles, and reset asserted mid-DRIVE → outputs blank immediately (registered), idx is held, then resumes. After reset, the buffers are 0 and an[0] first goes low 3 cycles after reset deasserts.
